// File: rtl/pb_io_pkg.sv
// Shared constants and address-decode helpers for the PicoBlaze I/O register file.
// Used by pb_io_regfile and pb_io_irq.
package pb_io_pkg;

    localparam int unsigned DATA_W          = 8;
    localparam int unsigned MAX_PORTS       = 16;
    localparam logic [7:0]  ALT_OFFSET_DEF  = 8'h10;
    localparam logic [7:0]  RB_BASE_DEF     = 8'h20;
    localparam logic [7:0]  STATUS_ADDR_DEF = 8'hFF;

    // True when port_id selects port k at its primary or mirrored address.
    function automatic logic addr_hit(input logic [7:0] port_id, input int unsigned k,
                                      input logic [7:0] offset);
        logic [7:0] base;
        base = k[7:0];
        return (port_id == base) || (port_id == 8'(base + offset));
    endfunction

    function automatic logic windows_overlap(input int unsigned a0, input int unsigned n0,
                                             input int unsigned a1, input int unsigned n1);
        return (a0 < a1 + n1) && (a1 < a0 + n0);
    endfunction

endpackage

// File: rtl/pb_io_irq.sv
// Interrupt pending flag with an 8-bit saturating counter of requests that arrived
// while an interrupt was already pending.
module pb_io_irq
    import pb_io_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic              i_ack,
    input  logic              i_clr,
    output logic              o_interrupt,
    output logic [DATA_W-1:0] o_missed
);

    logic              r_pending;
    logic [DATA_W-1:0] r_missed;
    logic              w_inc;

    assign w_inc = i_req && r_pending && !i_ack;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending <= 1'b0;
            r_missed  <= '0;
        end else begin
            // A new request wins over a simultaneous ack.
            if (i_req) begin
                r_pending <= 1'b1;
            end else if (i_ack) begin
                r_pending <= 1'b0;
            end
            if (i_clr) begin
                r_missed <= w_inc ? 8'd1 : 8'd0;
            end else if (w_inc && (r_missed != 8'hFF)) begin
                r_missed <= r_missed + 8'd1;
            end
        end
    end

    assign o_interrupt = r_pending;
    assign o_missed    = r_missed;

endmodule

// File: rtl/pb_io_regfile.sv
// Parametrised KCPSM6 I/O register file: mirrored input/output ports, registered read
// path, status register and interrupt handshake. PB_IO_READBACK_EN adds output readback.
module pb_io_regfile
    import pb_io_pkg::*;
#(
    parameter int unsigned N_IN        = 8,
    parameter int unsigned N_OUT       = 8,
    parameter logic [7:0]  ALT_OFFSET  = ALT_OFFSET_DEF,
    parameter logic [7:0]  RB_BASE     = RB_BASE_DEF,
    parameter logic [7:0]  STATUS_ADDR = STATUS_ADDR_DEF,
    parameter logic [7:0]  OUT_RESET   = 8'h00
) (
    input  logic                  sysclk,
    input  logic                  sysreset,
    input  logic [7:0]            port_id,
    input  logic                  write_strobe,
    input  logic                  read_strobe,
    input  logic [7:0]            io_data_in,
    output logic [7:0]            io_data_out,
    input  logic [N_IN*DATA_W-1:0]  in_ports,
    output logic [N_OUT*DATA_W-1:0] out_ports,
    input  logic                  interrupt_request,
    output logic                  interrupt,
    input  logic                  interrupt_ack
);

    localparam int unsigned N_MAX = (N_IN > N_OUT) ? N_IN : N_OUT;
    localparam int unsigned ALT_I = int'(ALT_OFFSET);
    localparam int unsigned RB_I  = int'(RB_BASE);
    localparam int unsigned ST_I  = int'(STATUS_ADDR);

    if (N_IN < 1 || N_IN > MAX_PORTS || N_OUT < 1 || N_OUT > MAX_PORTS) begin : g_bad_count
        $error("pb_io_regfile: N_IN and N_OUT must be in 1..16");
    end

    if (windows_overlap(0, N_MAX, ALT_I, N_MAX) || windows_overlap(0, N_MAX, RB_I, N_OUT) ||
        windows_overlap(ALT_I, N_MAX, RB_I, N_OUT) || windows_overlap(ST_I, 1, 0, N_MAX) ||
        windows_overlap(ST_I, 1, ALT_I, N_MAX) || windows_overlap(ST_I, 1, RB_I, N_OUT) ||
        (ALT_I + N_MAX > 256) || (RB_I + N_OUT > 256)) begin : g_bad_map
        $error("pb_io_regfile: address windows overlap");
    end

    logic [N_OUT*DATA_W-1:0] r_out;
    logic [DATA_W-1:0]       r_rd_data;
    logic [DATA_W-1:0]       w_rd_data;
    logic [DATA_W-1:0]       w_missed;
    logic                    w_status_clr;

    assign w_status_clr = read_strobe && (port_id == STATUS_ADDR);

    pb_io_irq u_irq (
        .i_clk       (sysclk),
        .i_rst       (sysreset),
        .i_req       (interrupt_request),
        .i_ack       (interrupt_ack),
        .i_clr       (w_status_clr),
        .o_interrupt (interrupt),
        .o_missed    (w_missed)
    );

    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            for (int unsigned k = 0; k < N_OUT; k++) begin
                r_out[8*k +: 8] <= OUT_RESET;
            end
        end else if (write_strobe) begin
            for (int unsigned k = 0; k < N_OUT; k++) begin
                if (addr_hit(port_id, k, ALT_OFFSET)) begin
                    r_out[8*k +: 8] <= io_data_in;
                end
            end
        end
    end

    // Priority: status, then readback window, then input decode.
    always_comb begin
        w_rd_data = '0;
        if (port_id == STATUS_ADDR) begin
            w_rd_data = w_missed;
        end
`ifdef PB_IO_READBACK_EN
        else if ((port_id >= RB_BASE) && (int'(port_id) < RB_I + N_OUT)) begin
            for (int unsigned k = 0; k < N_OUT; k++) begin
                if (port_id == 8'(RB_BASE + k[7:0])) begin
                    w_rd_data = r_out[8*k +: 8];
                end
            end
        end
`endif
        else begin
            for (int unsigned k = 0; k < N_IN; k++) begin
                if (addr_hit(port_id, k, ALT_OFFSET)) begin
                    w_rd_data = in_ports[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_data;
        end
    end

    assign io_data_out = r_rd_data;
    assign out_ports   = r_out;

endmodule

// File: doc/pb_io_regfile.md
Name: pb_io_regfile

Overview:
- Parametrised PicoBlaze (KCPSM6) I/O register file; successor to the fixed-port nexys4_if.
- Decodes port_id/strobes onto N_IN input ports and N_OUT output registers, each reachable at a primary and an alternate (mirrored) address.
- Provides a registered read path, interrupt request/ack handshake, and a missed-interrupt counter.
- Sits between kcpsm6 and the board/Rojobot I/O in the Nexys4 top level.

Parameters:
- N_IN, 8: number of 8-bit input ports (1..16).
- N_OUT, 8: number of 8-bit output registers (1..16).
- ALT_OFFSET, 8'h10: alternate-address offset; port k also answers at k+ALT_OFFSET.
- RB_BASE, 8'h20: base address of output readback window (optional feature).
- STATUS_ADDR, 8'hFF: status register address (read-only).
- OUT_RESET, 8'h00: reset value of every output register.

Ports:
- sysclk  in  1  system clock, 100 MHz.
- sysreset  in  1  reset, synchronous, active-high.
- port_id  in  8  PicoBlaze port address.
- write_strobe  in  1  PicoBlaze write strobe.
- read_strobe  in  1  PicoBlaze read strobe.
- io_data_in  in  8  data from PicoBlaze (out_port).
- io_data_out  out  8  data to PicoBlaze (in_port).
- in_ports  in  N_IN*8  packed input ports; port k = bits [8k+7:8k].
- out_ports  out  N_OUT*8  packed output registers, same packing.
- interrupt_request  in  1  single-cycle interrupt event.
- interrupt  out  1  to kcpsm6 interrupt.
- interrupt_ack  in  1  from kcpsm6.

Behaviour:
- Clock and reset: one clock (sysclk). sysreset is synchronous and active-high.
- Reset values: out_ports all OUT_RESET; io_data_out 0; interrupt 0; missed counter 0. A reset mid-sequence aborts a pending interrupt and clears all state on the next edge.
- Address map:
  - input k at k and k+ALT_OFFSET (k<N_IN);
  - output k at k and k+ALT_OFFSET (k<N_OUT);
  - status at STATUS_ADDR.
  - Reads and writes decode independently, so address k can be both input k and output k.
- Write: when write_strobe and port_id hits output k, out_ports[k] <= io_data_in at that edge (visible next cycle). Writes to unmapped addresses or STATUS_ADDR are ignored.
- Read path:
  - io_data_out is registered and updated every cycle from the current port_id, independent of read_strobe.
  - Latency is 1 cycle, which meets the KCPSM6 2-cycle in_port sampling window.
  - Unmapped address returns 8'h00.
  - Status reads return {missed[7:0]}.
- Interrupt:
  - interrupt_request sets pending; interrupt = pending.
  - interrupt_ack clears pending.
  - Request and ack in the same cycle: pending stays 1 (new event wins).
- Missed counter:
  - 8-bit, saturating at 8'hFF.
  - Increments when interrupt_request arrives while pending=1 and no ack in that cycle.
  - read_strobe with port_id==STATUS_ADDR clears it; a simultaneous increment event yields 1, not 0.
- Address priority: STATUS_ADDR > readback window > primary/alt input decode. Elaboration errors if N_IN or N_OUT >16, or if the address windows overlap.

Optional Feature:
- Macro: PB_IO_READBACK_EN.
- Defined: reads at RB_BASE+k (k<N_OUT) return out_ports[k] with the same 1-cycle latency.
- Undefined: those addresses read 8'h00, and no readback mux is generated.

Decomposition:
- Package pb_io_pkg holds: DATA_W=8, MAX_PORTS=16, default ALT_OFFSET/RB_BASE/STATUS_ADDR constants, and an addr_hit function (port_id, k, offset).
- One natural sub-module, pb_io_irq: pending flag plus saturating missed counter, with ports req/ack/clr/interrupt/missed.

Test Plan:
- Reset: hold sysreset 2 cycles -> out_ports all 8'h00, interrupt 0, read STATUS_ADDR gives 8'h00.
- Write via both addresses: write 8'hA5 to 8'h03, then 8'h5A to 8'h13 -> out_ports[3]=A5 the cycle after the first write, then 5A; other outputs unchanged.
- Read path: in_ports[2]=8'h3C, port_id=8'h12 -> io_data_out=8'h3C one cycle later; port_id=8'h40 -> 8'h00.
- Interrupt handshake: request pulse -> interrupt=1 next cycle. Two more pulses before ack -> status reads 8'h02 and a following read gives 8'h00. Ack -> interrupt=0. Request+ack together -> interrupt stays 1.
- Saturation and clear: 300 requests while pending -> status 8'hFF. Clear coincident with a request -> status 8'h01 afterwards.
- With PB_IO_READBACK_EN: write 8'h77 to output 5 -> reading 8'h25 returns 8'h77. Without the macro -> 8'h00.
